// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state,
// read-return ownership, and the byte-enable value used on reads/idle.
package dm_arb_pkg;

   typedef enum logic {
      ARB_A   = 1'b0,
      B_BURST = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_A    = 2'd1,
      OWNER_B    = 2'd2
   } rd_owner_t;

   localparam logic [3:0] DM_BE_NONE = 4'b0000;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear. Clear and increment in the same cycle
// restart the count at one, which lets a burst start on its first beat.
module arb_sat_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] base;

   // Starting point for this cycle's update: zero when clearing.
   always_comb begin
      base = clr ? '0 : cnt;
   end

   // Count register: add one on inc, never beyond LIMIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (inc && (base < LIMIT_V)) begin
         cnt <= base + WIDTH'(1);
      end else begin
         cnt <= base;
      end
   end

   assign sat = (cnt == LIMIT_V);

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Port A (CPU MEM
// stage) has priority; port B gets a guaranteed slot after STARVE_LIMIT
// denied cycles and may hold the memory for locked bursts of up to
// BURST_MAX beats. Read data returns one cycle after the read grant.
module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW           = 12,
   parameter int STARVE_LIMIT = 4,
   parameter int BURST_MAX    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [3:0]    a_be,
   input  logic [AW-1:0] a_addr,
   input  logic [31:0]   a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [31:0]   a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [3:0]    b_be,
   input  logic [AW-1:0] b_addr,
   input  logic [31:0]   b_wdata,
   input  logic          b_lock,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [31:0]   b_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          stall_mem
);

   arb_state_t state;
   rd_owner_t  rd_owner;

   logic starve_sat;
   logic beat_sat;
   logic burst_cont;
   logic burst_exit;
   logic arb_rules;
   logic b_eligible;

   // Counts consecutive cycles B waited; saturation forces a B slot.
   arb_sat_counter #(
      .WIDTH (4),
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (b_req & ~b_gnt),
      .clr   (b_gnt),
      .sat   (starve_sat)
   );

   // Counts beats of a locked B burst; held at zero outside bursts.
   arb_sat_counter #(
      .WIDTH (8),
      .LIMIT (BURST_MAX)
   ) u_beat_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (b_gnt & b_lock),
      .clr   (arb_rules),
      .sat   (beat_sat)
   );

   // Grant decision. A burst that just used its last beat may not be
   // re-granted in its exit cycle, so the others get a turn first.
   always_comb begin
      burst_cont = (state == B_BURST) & b_req & b_lock & ~beat_sat;
      burst_exit = (state == B_BURST) & ~burst_cont;
      arb_rules  = (state == ARB_A) | burst_exit;
      b_eligible = b_req & ~(burst_exit & beat_sat);
      a_gnt      = arb_rules & a_req & ~(starve_sat & b_eligible);
      b_gnt      = burst_cont | (arb_rules & b_eligible & ~a_gnt);
      stall_mem  = a_req & ~a_gnt;
   end

   // Memory-side mux from whichever port holds the grant this cycle.
   always_comb begin
      mem_en    = a_gnt | b_gnt;
      mem_we    = 1'b0;
      mem_be    = DM_BE_NONE;
      mem_addr  = '0;
      mem_wdata = '0;
      if (a_gnt) begin
         mem_we    = a_we;
         mem_be    = a_we ? a_be : DM_BE_NONE;
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
      end else if (b_gnt) begin
         mem_we    = b_we;
         mem_be    = b_we ? b_be : DM_BE_NONE;
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
      end
   end

   // Arbitration FSM: a locked B grant enters or continues a burst.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ARB_A;
      end else if (b_gnt && b_lock) begin
         state <= B_BURST;
      end else begin
         state <= ARB_A;
      end
   end

   // Remembers which port's read is in flight so the return is steered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_owner <= OWNER_NONE;
      end else if (a_gnt && !a_we) begin
         rd_owner <= OWNER_A;
      end else if (b_gnt && !b_we) begin
         rd_owner <= OWNER_B;
      end else begin
         rd_owner <= OWNER_NONE;
      end
   end

   assign a_rvalid = (rd_owner == OWNER_A);
   assign b_rvalid = (rd_owner == OWNER_B);
   assign a_rdata  = a_rvalid ? mem_rdata : 32'h0;
   assign b_rdata  = b_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: stimulus pushes expected grants and
// read returns, a negedge monitor pops and compares them as they appear.
module tb_dm_port_arbiter;

   logic        clk;
   logic        reset;
   logic        a_req, a_we;
   logic [3:0]  a_be;
   logic [11:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_gnt, a_rvalid;
   logic [31:0] a_rdata;
   logic        b_req, b_we, b_lock;
   logic [3:0]  b_be;
   logic [11:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_gnt, b_rvalid;
   logic [31:0] b_rdata;
   logic        mem_en, mem_we;
   logic [3:0]  mem_be;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_mem;

   typedef struct packed {
      logic [31:0] cyc;
      logic        port;
      logic        we;
      logic [3:0]  be;
      logic [11:0] addr;
      logic [31:0] wdata;
   } gnt_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic        port;
      logic [31:0] data;
   } rd_t;

   gnt_t gnt_q[$];
   rd_t  rd_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic mon_en = 1'b0;
   logic [31:0] dm [0:4095];

   dm_port_arbiter #(
      .AW           (12),
      .STARVE_LIMIT (4),
      .BURST_MAX    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_be      (a_be),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_gnt     (a_gnt),
      .a_rvalid  (a_rvalid),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_be      (b_be),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_lock    (b_lock),
      .b_gnt     (b_gnt),
      .b_rvalid  (b_rvalid),
      .b_rdata   (b_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_mem (stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port data memory with one-cycle read latency.
   always @(posedge clk) begin
      if (!reset) begin
         dm[12'h010] <= 32'hDEADBEEF;
         dm[12'h020] <= 32'h11112222;
         dm[12'h030] <= 32'h33334444;
      end else if (mem_en) begin
         if (!mem_we) begin
            mem_rdata <= dm[mem_addr];
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (mem_be[i]) dm[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   task checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task reportUnexpected(input string name);
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: output at cycle %0d with nothing expected", name, cyc);
   endtask

   task expectGrant(input int c, input logic port, input logic we, input logic [3:0] be,
                    input logic [11:0] addr, input logic [31:0] wdata);
      gnt_t e;
      e.cyc = c; e.port = port; e.we = we; e.be = be; e.addr = addr; e.wdata = wdata;
      gnt_q.push_back(e);
   endtask

   task expectRead(input int c, input logic port, input logic [31:0] data);
      rd_t e;
      e.cyc = c; e.port = port; e.data = data;
      rd_q.push_back(e);
   endtask

   task applyStimulus(input logic ar, input logic aw, input logic [3:0] abe, input logic [11:0] aad,
                      input logic [31:0] awd, input logic br, input logic bw, input logic bl,
                      input logic [3:0] bbe, input logic [11:0] bad, input logic [31:0] bwd);
      @(posedge clk);
      #1;
      a_req = ar; a_we = aw; a_be = abe; a_addr = aad; a_wdata = awd;
      b_req = br; b_we = bw; b_lock = bl; b_be = bbe; b_addr = bad; b_wdata = bwd;
   endtask

   task applyIdle;
      applyStimulus(0, 0, 4'h0, 12'h0, 32'h0, 0, 0, 0, 4'h0, 12'h0, 32'h0);
   endtask

   // Monitor: pops expectations whenever the DUT issues a grant or returns data.
   always @(negedge clk) begin
      gnt_t ge, ga;
      rd_t  re, ra;
      if (mon_en) begin
         checkOutput("single_grant", a_gnt & b_gnt, 0);
         checkOutput("single_rvalid", a_rvalid & b_rvalid, 0);
         if (!a_rvalid) checkOutput("a_rdata_idle", a_rdata, 0);
         if (!b_rvalid) checkOutput("b_rdata_idle", b_rdata, 0);
         if (mem_en) begin
            if (gnt_q.size() == 0) begin
               reportUnexpected("unexpected_grant");
            end else begin
               ge = gnt_q.pop_front();
               ga.cyc = cyc; ga.port = b_gnt; ga.we = mem_we; ga.be = mem_be;
               ga.addr = mem_addr; ga.wdata = mem_wdata;
               checkOutput("grant", ga, ge);
            end
         end
         if (a_rvalid || b_rvalid) begin
            if (rd_q.size() == 0) begin
               reportUnexpected("unexpected_rvalid");
            end else begin
               re = rd_q.pop_front();
               ra.cyc = cyc; ra.port = b_rvalid; ra.data = b_rvalid ? b_rdata : a_rdata;
               checkOutput("read_return", ra, re);
            end
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      int c0;
      int beat;
      reset = 1'b0;
      a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_lock = 0; b_be = 0; b_addr = 0; b_wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] reset state checks");
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_be", mem_be, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_a_rvalid", a_rvalid, 0);
      checkOutput("rst_b_rvalid", b_rvalid, 0);
      checkOutput("rst_stall", stall_mem, 0);
      reset = 1'b1;
      mon_en = 1'b1;

      // Single A read.
      $display("[TB] lone A read");
      applyStimulus(1, 0, 4'hF, 12'h010, 32'h0, 0, 0, 0, 4'h0, 12'h0, 32'h0);
      expectGrant(cyc, 0, 0, 4'h0, 12'h010, 32'h0);
      expectRead(cyc + 1, 0, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("t1_stall", stall_mem, 0);
      applyIdle;

      // A and B contend continuously: A four times, B forced, then A.
      $display("[TB] starvation slot");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 0, 4'h0, 12'h020, 32'h0, 1, 0, 0, 4'h0, 12'h030, 32'h0);
         if (i == 4) begin
            expectGrant(cyc, 1, 0, 4'h0, 12'h030, 32'h0);
            expectRead(cyc + 1, 1, 32'h33334444);
         end else begin
            expectGrant(cyc, 0, 0, 4'h0, 12'h020, 32'h0);
            expectRead(cyc + 1, 0, 32'h11112222);
         end
         @(negedge clk);
         checkOutput("t2_stall", stall_mem, (i == 4));
      end
      applyIdle;

      // Ten-beat locked burst: 8 beats, one idle cycle, remaining 2 beats.
      $display("[TB] burst cap");
      beat = 0;
      for (int k = 0; k < 11; k++) begin
         applyStimulus(0, 0, 4'h0, 12'h0, 32'h0, 1, 1, 1, 4'hF, 12'h100 + 12'(beat), 32'hB3000000 + beat);
         if (k != 8) begin
            expectGrant(cyc, 1, 1, 4'hF, 12'h100 + 12'(beat), 32'hB3000000 + beat);
            beat++;
         end
      end
      applyIdle;

      // A partial write waits out a B burst.
      $display("[TB] A write behind burst");
      applyStimulus(0, 0, 4'h0, 12'h0, 32'h0, 1, 1, 1, 4'hF, 12'h200, 32'hB4000000);
      expectGrant(cyc, 1, 1, 4'hF, 12'h200, 32'hB4000000);
      for (int k = 1; k < 3; k++) begin
         applyStimulus(1, 1, 4'b0011, 12'h010, 32'hCAFEF00D, 1, 1, 1, 4'hF, 12'h200 + 12'(k), 32'hB4000000 + k);
         expectGrant(cyc, 1, 1, 4'hF, 12'h200 + 12'(k), 32'hB4000000 + k);
         @(negedge clk);
         checkOutput("t4_stall_burst", stall_mem, 1);
      end
      applyStimulus(1, 1, 4'b0011, 12'h010, 32'hCAFEF00D, 0, 0, 0, 4'h0, 12'h0, 32'h0);
      expectGrant(cyc, 0, 1, 4'b0011, 12'h010, 32'hCAFEF00D);
      @(negedge clk);
      checkOutput("t4_stall_after", stall_mem, 0);
      applyIdle;

      // Alternating reads A, B, A.
      $display("[TB] alternating reads");
      applyStimulus(1, 0, 4'h0, 12'h010, 32'h0, 0, 0, 0, 4'h0, 12'h0, 32'h0);
      expectGrant(cyc, 0, 0, 4'h0, 12'h010, 32'h0);
      expectRead(cyc + 1, 0, 32'hDEADF00D);
      applyStimulus(0, 0, 4'h0, 12'h0, 32'h0, 1, 0, 0, 4'h0, 12'h201, 32'h0);
      expectGrant(cyc, 1, 0, 4'h0, 12'h201, 32'h0);
      expectRead(cyc + 1, 1, 32'hB4000001);
      applyStimulus(1, 0, 4'h0, 12'h020, 32'h0, 0, 0, 0, 4'h0, 12'h0, 32'h0);
      expectGrant(cyc, 0, 0, 4'h0, 12'h020, 32'h0);
      expectRead(cyc + 1, 0, 32'h11112222);
      applyIdle;

      // Reset right after a B read grant drops the return.
      $display("[TB] reset during read");
      applyStimulus(0, 0, 4'h0, 12'h0, 32'h0, 1, 0, 0, 4'h0, 12'h030, 32'h0);
      expectGrant(cyc, 1, 0, 4'h0, 12'h030, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      b_req = 1'b0;
      @(negedge clk);
      checkOutput("t6_b_rvalid", b_rvalid, 0);
      checkOutput("t6_b_rdata", b_rdata, 0);
      checkOutput("t6_mem_en", mem_en, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      applyStimulus(1, 0, 4'h0, 12'h020, 32'h0, 1, 0, 0, 4'h0, 12'h030, 32'h0);
      expectGrant(cyc, 0, 0, 4'h0, 12'h020, 32'h0);
      expectRead(cyc + 1, 0, 32'h11112222);
      applyStimulus(0, 0, 4'h0, 12'h0, 32'h0, 1, 0, 0, 4'h0, 12'h030, 32'h0);
      expectGrant(cyc, 1, 0, 4'h0, 12'h030, 32'h0);
      expectRead(cyc + 1, 1, 32'h33334444);
      applyIdle;

      for (int t = 0; t < 20 && (gnt_q.size() != 0 || rd_q.size() != 0); t++) @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput("gnt_queue_drained", gnt_q.size(), 0);
      checkOutput("rd_queue_drained", rd_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
